// File: rtl/mul_alu_pipe.sv
// Fully pipelined WIDTH x WIDTH multiplier with valid/ready handshake and tag pass-through.
// Operands are captured on accept; the product is formed after capture and then travels LAT-1 further stages.
module mul_alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned PW = 2 * WIDTH;

  logic             en;
  logic [LAT:0]     vld_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       mode_q;
  logic [TAG_W-1:0] tag_q  [0:LAT];
  logic [PW-1:0]    prod_q [1:LAT];

  logic          a_sx;
  logic          b_sx;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod_c;

  // Extend both operands to full product width; mode 11 falls through as unsigned.
  always_comb begin
    a_sx   = ((mode_q == 2'b01) || (mode_q == 2'b10)) && a_q[WIDTH-1];
    b_sx   = (mode_q == 2'b01) && b_q[WIDTH-1];
    a_ext  = {{WIDTH{a_sx}}, a_q};
    b_ext  = {{WIDTH{b_sx}}, b_q};
    prod_c = a_ext * b_ext;
  end

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[LAT];
  assign result    = prod_q[LAT];
  assign out_tag   = tag_q[LAT];
  assign busy      = |vld_q;

  // Whole pipeline shifts together (bubbles included) whenever the output can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      for (int i = 0; i <= int'(LAT); i++) tag_q[i] <= '0;
      for (int i = 1; i <= int'(LAT); i++) prod_q[i] <= '0;
    end else if (en) begin
      vld_q     <= {vld_q[LAT-1:0], in_valid};
      a_q       <= a;
      b_q       <= b;
      mode_q    <= mode;
      tag_q[0]  <= in_tag;
      prod_q[1] <= prod_c;
      for (int i = 1; i <= int'(LAT); i++) tag_q[i] <= tag_q[i-1];
      for (int i = 2; i <= int'(LAT); i++) prod_q[i] <= prod_q[i-1];
    end
  end

endmodule

// File: tb/tb_mul_alu_pipe.sv
// Directed bench for mul_alu_pipe: scoreboard of expected products, checked when results are consumed.
module tb_mul_alu_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LAT   = 4;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  always #5 clk = ~clk;

  mul_alu_pipe #(.WIDTH(WIDTH), .LAT(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .busy(busy)
  );

  typedef struct {
    logic [15:0] res;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  logic rdy_s;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Independent reference: widen each operand according to its signedness, multiply, keep 16 bits.
  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] m);
    int x;
    int y;
    x = (m == 2'b01 || m == 2'b10) ? int'($signed(av)) : int'(av);
    y = (m == 2'b01) ? int'($signed(bv)) : int'(bv);
    return 16'(x * y);
  endfunction

  // One clock: sample/score at the falling edge, then return 1 time unit after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk);
    rdy_s = in_ready;
    if (out_valid === 1'b1 && out_ready) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end else begin
      run_len = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] m,
                      input logic [3:0] t, input logic [15:0] er, input bit expect_ready);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    mode     = m;
    in_tag   = t;
    for (int i = 0; i < 30; i++) begin
      step();
      if (expect_ready && i == 0) chk("in_ready_on_send", 32'(rdy_s), 32'd1);
      if (rdy_s === 1'b1) begin
        sb.push_back('{er, t});
        return;
      end
    end
    chk("accept_timeout", 32'(rdy_s), 32'd1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (sb.size() != 0 || busy !== 1'b0); i++) step();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  logic [7:0]  da [6] = '{8'd0,    8'h80,    8'hFF,    8'h7F,    8'hFF,    8'hFF};
  logic [7:0]  db [6] = '{8'd200,  8'h80,    8'h01,    8'h80,    8'hFF,    8'hFF};
  logic [1:0]  dm [6] = '{2'b00,   2'b01,    2'b01,    2'b01,    2'b10,    2'b11};
  logic [15:0] dr [6] = '{16'h0000, 16'h4000, 16'hFFFF, 16'hC080, 16'hFF01, 16'hFE01};

  initial begin
    logic [7:0] av;
    logic [7:0] bv;
    logic [1:0] m;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency of a single unsigned operation
    send(8'd255, 8'd255, 2'b00, 4'd3, 16'hFE01, 1'b1);
    in_valid = 1'b0;
    for (int i = 1; i < int'(LAT); i++) begin
      step();
      chk("lat_no_valid_early", 32'(out_valid), 32'd0);
    end
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_result", 32'(result), 32'hFE01);
    chk("lat_tag", 32'(out_tag), 32'd3);
    drain();

    // Directed mode cases, issued back to back
    for (int i = 0; i < 6; i++) send(da[i], db[i], dm[i], 4'(i + 1), dr[i], 1'b1);
    drain();

    // 16 consecutive random ops, tags 0..15
    max_run = 0;
    for (int i = 0; i < 16; i++) begin
      av = 8'($urandom);
      bv = 8'($urandom);
      m  = 2'($urandom_range(0, 3));
      send(av, bv, m, 4'(i), model(av, bv, m), 1'b1);
    end
    drain();
    chk("b2b_consecutive_outputs", 32'(max_run), 32'd16);

    // Backpressure with three ops in flight and a pending input
    send(8'd1, 8'd2, 2'b00, 4'd10, 16'd2, 1'b1);
    send(8'd3, 8'd4, 2'b00, 4'd11, 16'd12, 1'b1);
    send(8'd5, 8'd6, 2'b01, 4'd12, 16'd30, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) step();
    chk("bp_out_valid_seen", 32'(out_valid), 32'd1);
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd7; b = 8'd8; mode = 2'b00; in_tag = 4'd13;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result_held", 32'(result), 32'(sb[0].res));
      chk("bp_tag_held", 32'(out_tag), 32'(sb[0].tag));
    end
    out_ready = 1'b1;
    send(8'd7, 8'd8, 2'b00, 4'd13, 16'd56, 1'b1);
    drain();

    // Reset with three ops in flight
    send(8'd9, 8'd9, 2'b00, 4'd5, 16'd81, 1'b1);
    send(8'hF0, 8'd2, 2'b01, 4'd6, model(8'hF0, 8'd2, 2'b01), 1'b1);
    send(8'd3, 8'hFE, 2'b10, 4'd7, model(8'd3, 8'hFE, 2'b10), 1'b1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    step();
    rst_n = 1'b1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 2 * int'(LAT); i++) begin
      step();
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
